// File: rtl/cal_pkg.sv
// Shared calendar definitions for the date keeper and its helpers.
//   - width constants for year / month / day / weekday fields
//   - weekday and month enums, FSM state enum
//   - leap counter bundle and its epoch load value
//   - days_in_month() and wday_add() (mod-7 add without a divider)
package cal_pkg;

  localparam int YEAR_W  = 12;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int WDAY_W  = 3;

  typedef enum logic [WDAY_W-1:0] {MON, TUE, WED, THU, FRI, SAT, SUN} wday_e;

  typedef enum logic [MONTH_W-1:0] {
    JAN, FEB, MAR, APR, MAY, JUN, JUL, AUG, SEP, OCT, NOV, DEC
  } month_e;

  typedef enum logic [1:0] {IDLE, YEAR_WALK, MONTH_WALK, COMMIT} date_state_e;

  // Year modulo 4 / 100 / 400, stepped alongside the year value.
  typedef struct packed {
    logic [8:0] m400;
    logic [6:0] m100;
    logic [1:0] m4;
  } leap_cnt_t;

  function automatic leap_cnt_t epoch_cnt(input int year);
    leap_cnt_t r;
    r.m400 = 9'(year % 400);
    r.m100 = 7'(year % 100);
    r.m4   = 2'(year % 4);
    return r;
  endfunction

  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] m,
                                                     input logic leap);
    case (month_e'(m))
      FEB:                return leap ? 5'd29 : 5'd28;
      APR, JUN, SEP, NOV: return 5'd30;
      default:            return 5'd31;
    endcase
  endfunction

  // (w + n) mod 7 for w <= 6, n <= 31. The sum is at most 37, so three
  // compare-subtract stages (28, 14, 7) always land in 0..6.
  function automatic logic [WDAY_W-1:0] wday_add(input logic [WDAY_W-1:0] w,
                                                 input logic [DAY_W-1:0] n);
    logic [5:0] s;
    s = {3'd0, w} + {1'b0, n};
    if (s >= 6'd28) s = s - 6'd28;
    if (s >= 6'd14) s = s - 6'd14;
    if (s >= 6'd7)  s = s - 6'd7;
    return s[WDAY_W-1:0];
  endfunction

endpackage

// File: rtl/leap_tracker.sv
// Tracks a year's residues mod 4/100/400 so the leap flag needs no divider.
//   clk, rst_n  : clock, asynchronous active-low reset (resets to MIN_YEAR)
//   load_i      : load load_val_i (takes priority over inc_i)
//   load_val_i  : counter values to load
//   inc_i       : step the tracked year by one
//   cnt_o       : current residues
//   leap_o      : tracked year is a leap year
module leap_tracker
  import cal_pkg::*;
#(
  parameter int MIN_YEAR = 2000
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load_i,
  input  leap_cnt_t load_val_i,
  input  logic      inc_i,
  output leap_cnt_t cnt_o,
  output logic      leap_o
);

  localparam leap_cnt_t RESET_CNT = epoch_cnt(MIN_YEAR);

  leap_cnt_t cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RESET_CNT;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (inc_i) begin
      cnt.m4   <= cnt.m4 + 2'd1;
      cnt.m100 <= (cnt.m100 == 7'd99)  ? 7'd0 : cnt.m100 + 7'd1;
      cnt.m400 <= (cnt.m400 == 9'd399) ? 9'd0 : cnt.m400 + 9'd1;
    end
  end

  assign cnt_o  = cnt;
  assign leap_o = ((cnt.m4 == 2'd0) && (cnt.m100 != 7'd0)) || (cnt.m400 == 9'd0);

endmodule

// File: rtl/date_keeper.sv
// Owns the live calendar date and drives the date_if fields.
//   clk_50_i, rst_n_i      : clock, asynchronous active-low reset
//   day_tick_i             : midnight pulse, advances the date by one day
//   set_valid_i/set_ready_o: date-set handshake
//   set_year_i/month/day   : requested date (month 0-based, day 1-based)
//   set_done_o/set_err_o   : one-cycle result pulses of a set
//   year_o .. month_days_cnt_o : live date fields, all updated on the same edge
//   fsm_state_o            : current FSM state (debug)
//
// Handshake: a set transfers on a rising edge where set_valid_i && set_ready_o;
// the request fields are captured on that edge. set_ready_o is high only in
// IDLE and stays low from acceptance until the cycle after COMMIT, which is
// also the cycle carrying the set_done_o or set_err_o pulse.
module date_keeper
  import cal_pkg::*;
#(
  parameter int MIN_YEAR   = 2000,
  parameter int MAX_YEAR   = 2999,
  parameter int EPOCH_WDAY = 5
) (
  input  logic               clk_50_i,
  input  logic               rst_n_i,
  input  logic               day_tick_i,
  input  logic               set_valid_i,
  output logic               set_ready_o,
  input  logic [YEAR_W-1:0]  set_year_i,
  input  logic [MONTH_W-1:0] set_month_i,
  input  logic [DAY_W-1:0]   set_day_i,
  output logic               set_done_o,
  output logic               set_err_o,
  output logic [YEAR_W-1:0]  year_o,
  output logic [MONTH_W-1:0] month_o,
  output logic [DAY_W-1:0]   day_in_month_o,
  output logic [WDAY_W-1:0]  day_of_week_o,
  output logic [WDAY_W-1:0]  month_first_day_o,
  output logic [DAY_W-1:0]   month_days_cnt_o,
  output logic [1:0]         fsm_state_o
);

  localparam logic [YEAR_W-1:0] MIN_Y     = YEAR_W'(MIN_YEAR);
  localparam logic [YEAR_W-1:0] MAX_Y     = YEAR_W'(MAX_YEAR);
  localparam logic [WDAY_W-1:0] EPOCH_W   = WDAY_W'(EPOCH_WDAY);
  localparam leap_cnt_t         EPOCH_CNT = epoch_cnt(MIN_YEAR);

  date_state_e        state;
  logic [YEAR_W-1:0]  t_year, wy;
  logic [MONTH_W-1:0] t_month, wm;
  logic [DAY_W-1:0]   t_day;
  logic [WDAY_W-1:0]  ww;
  logic               range_err;

  logic      live_leap, walk_leap;
  leap_cnt_t live_cnt, walk_cnt, live_load_val;
  logic      live_load, live_inc, walk_load, walk_inc;
  logic      tick_ok, month_end, year_end, commit_ok, req_bad;
  logic      unused_live_cnt;

  // A set accepted in the same cycle as a tick wins; ticks outside IDLE drop.
  assign tick_ok   = (state == IDLE) && !set_valid_i && day_tick_i;
  assign month_end = !(day_in_month_o < month_days_cnt_o);
  assign year_end  = month_end && (month_o == 4'd11);
  assign req_bad   = (set_year_i < MIN_Y) || (set_year_i > MAX_Y) || (set_month_i > 4'd11);
  assign commit_ok = (state == COMMIT) && !range_err && (t_day != 5'd0) &&
                     (t_day <= days_in_month(t_month, walk_leap));

  // Walk tracker restarts at the epoch for each set; on a good commit the
  // live tracker takes over the walk tracker's residues for the new year.
  assign walk_load     = (state == IDLE) && set_valid_i;
  assign walk_inc      = (state == YEAR_WALK);
  assign live_load     = commit_ok || (tick_ok && year_end && (year_o == MAX_Y));
  assign live_inc      = tick_ok && year_end && (year_o != MAX_Y);
  assign live_load_val = commit_ok ? walk_cnt : EPOCH_CNT;
  assign unused_live_cnt = ^live_cnt;

  leap_tracker #(.MIN_YEAR(MIN_YEAR)) u_live_leap (
    .clk        (clk_50_i),
    .rst_n      (rst_n_i),
    .load_i     (live_load),
    .load_val_i (live_load_val),
    .inc_i      (live_inc),
    .cnt_o      (live_cnt),
    .leap_o     (live_leap)
  );

  leap_tracker #(.MIN_YEAR(MIN_YEAR)) u_walk_leap (
    .clk        (clk_50_i),
    .rst_n      (rst_n_i),
    .load_i     (walk_load),
    .load_val_i (EPOCH_CNT),
    .inc_i      (walk_inc),
    .cnt_o      (walk_cnt),
    .leap_o     (walk_leap)
  );

  always_ff @(posedge clk_50_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state             <= IDLE;
      set_ready_o       <= 1'b1;
      set_done_o        <= 1'b0;
      set_err_o         <= 1'b0;
      year_o            <= MIN_Y;
      month_o           <= 4'd0;
      day_in_month_o    <= 5'd1;
      day_of_week_o     <= EPOCH_W;
      month_first_day_o <= EPOCH_W;
      month_days_cnt_o  <= 5'd31;
      t_year            <= MIN_Y;
      t_month           <= 4'd0;
      t_day             <= 5'd1;
      wy                <= MIN_Y;
      wm                <= 4'd0;
      ww                <= EPOCH_W;
      range_err         <= 1'b0;
    end else begin
      set_done_o <= 1'b0;
      set_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (set_valid_i) begin
            t_year      <= set_year_i;
            t_month     <= set_month_i;
            t_day       <= set_day_i;
            wy          <= MIN_Y;
            wm          <= 4'd0;
            ww          <= EPOCH_W;
            set_ready_o <= 1'b0;
            range_err   <= req_bad;
            // Skip walk phases that would do zero steps so the latency is
            // exactly (year-MIN_YEAR) + month + 2.
            if (req_bad)                 state <= COMMIT;
            else if (set_year_i != MIN_Y) state <= YEAR_WALK;
            else if (set_month_i != 4'd0) state <= MONTH_WALK;
            else                          state <= COMMIT;
          end else if (tick_ok) begin
            day_of_week_o <= wday_add(day_of_week_o, 5'd1);
            if (!month_end) begin
              day_in_month_o <= day_in_month_o + 5'd1;
            end else begin
              day_in_month_o <= 5'd1;
              if (month_o == 4'd11) begin
                month_o          <= 4'd0;
                month_days_cnt_o <= 5'd31;
                if (year_o == MAX_Y) begin
                  year_o            <= MIN_Y;
                  month_first_day_o <= EPOCH_W;
                  day_of_week_o     <= EPOCH_W;
                end else begin
                  year_o            <= year_o + YEAR_W'(1);
                  month_first_day_o <= wday_add(month_first_day_o, month_days_cnt_o);
                end
              end else begin
                month_o           <= month_o + 4'd1;
                month_first_day_o <= wday_add(month_first_day_o, month_days_cnt_o);
                month_days_cnt_o  <= days_in_month(month_o + 4'd1, live_leap);
              end
            end
          end
        end
        YEAR_WALK: begin
          ww <= wday_add(ww, 5'd1 + 5'(walk_leap));
          wy <= wy + YEAR_W'(1);
          if (wy + YEAR_W'(1) == t_year) state <= (t_month == 4'd0) ? COMMIT : MONTH_WALK;
        end
        MONTH_WALK: begin
          ww <= wday_add(ww, days_in_month(wm, walk_leap));
          wm <= wm + 4'd1;
          if (wm + 4'd1 == t_month) state <= COMMIT;
        end
        COMMIT: begin
          if (commit_ok) begin
            year_o            <= t_year;
            month_o           <= t_month;
            day_in_month_o    <= t_day;
            month_first_day_o <= ww;
            day_of_week_o     <= wday_add(ww, t_day - 5'd1);
            month_days_cnt_o  <= days_in_month(t_month, walk_leap);
            set_done_o        <= 1'b1;
          end else begin
            set_err_o <= 1'b1;
          end
          set_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_state_o = state;

endmodule

// File: tb/tb_date_keeper.sv
// Directed bench for date_keeper. Expected dates are hand-computed.
module tb_date_keeper;
  import cal_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              day_tick, set_valid, set_ready, set_done, set_err;
  logic [YEAR_W-1:0] set_year, year;
  logic [3:0]        set_month, month;
  logic [4:0]        set_day, day, days_cnt;
  logic [2:0]        dow, first_day;
  logic [1:0]        fsm_state;
  logic [31:0]       snap;

  date_keeper dut (
    .clk_50_i          (clk),
    .rst_n_i           (rst_n),
    .day_tick_i        (day_tick),
    .set_valid_i       (set_valid),
    .set_ready_o       (set_ready),
    .set_year_i        (set_year),
    .set_month_i       (set_month),
    .set_day_i         (set_day),
    .set_done_o        (set_done),
    .set_err_o         (set_err),
    .year_o            (year),
    .month_o           (month),
    .day_in_month_o    (day),
    .day_of_week_o     (dow),
    .month_first_day_o (first_day),
    .month_days_cnt_o  (days_cnt),
    .fsm_state_o       (fsm_state)
  );

  assign snap = {year, month, day, dow, first_day, days_cnt};

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int          exp_at_q[$];

  function automatic logic [31:0] mk(input int y, input int m, input int d,
                                     input int w, input int f, input int c);
    return {12'(y), 4'(m), 5'(d), 3'(w), 3'(f), 5'(c)};
  endfunction

  function automatic string fmt(input logic [31:0] s);
    return $sformatf("%0d/%0d/%0d dow=%0d first=%0d cnt=%0d",
                     s[31:20], s[19:16], s[15:11], s[10:8], s[7:5], s[4:0]);
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a set for one cycle and waits for the result pulse. lat counts
  // negedges after the acceptance edge; -1 means no pulse arrived.
  task automatic do_set(input int y, input int m, input int d,
                        output int lat, output logic done, output logic err);
    @(negedge clk);
    set_year = 12'(y); set_month = 4'(m); set_day = 5'(d); set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    lat = 1; done = set_done; err = set_err;
    while (!done && !err && lat < 1500) begin
      @(negedge clk);
      lat++; done = set_done; err = set_err;
    end
    if (!done && !err) lat = -1;
  endtask

  task automatic tick();
    @(negedge clk); day_tick = 1'b1;
    @(negedge clk); day_tick = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total++;
    if (snap !== mk(2000, 0, 1, 5, 5, 31)) begin
      bad++; $display("FAIL reset_date: got %s want %s", fmt(snap), fmt(mk(2000, 0, 1, 5, 5, 31)));
    end
    total++;
    if ({set_ready, set_done, set_err, fsm_state} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl: got ready=%b done=%b err=%b state=%0d want 1 0 0 0",
                      set_ready, set_done, set_err, fsm_state);
    end
  endtask

  task automatic test_set_leap();
    int lat; logic done, err;
    do_set(2024, 1, 10, lat, done, err);
    total++;
    if (lat !== 27 || done !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL set_2024_latency: got lat=%0d done=%b err=%b want 27 1 0", lat, done, err);
    end
    total++;
    if (snap !== mk(2024, 1, 10, 5, 3, 29)) begin
      bad++; $display("FAIL set_2024_date: got %s want %s", fmt(snap), fmt(mk(2024, 1, 10, 5, 3, 29)));
    end
    total++;
    if (set_ready !== 1'b1) begin
      bad++; $display("FAIL set_ready_after_done: got %b want 1", set_ready);
    end
    @(negedge clk);
    total++;
    if (set_done !== 1'b0) begin
      bad++; $display("FAIL done_one_cycle: got %b want 0", set_done);
    end
  endtask

  task automatic test_tick_month_end();
    int lat; logic done, err;
    do_set(2024, 1, 29, lat, done, err);
    total++;
    if (lat !== 27 || done !== 1'b1 || snap !== mk(2024, 1, 29, 3, 3, 29)) begin
      bad++; $display("FAIL set_feb29: got lat=%0d done=%b %s want 27 1 %s",
                      lat, done, fmt(snap), fmt(mk(2024, 1, 29, 3, 3, 29)));
    end
    tick();
    total++;
    if (snap !== mk(2024, 2, 1, 4, 4, 31)) begin
      bad++; $display("FAIL tick_feb29: got %s want %s", fmt(snap), fmt(mk(2024, 2, 1, 4, 4, 31)));
    end
    tick();
    total++;
    if (snap !== mk(2024, 2, 2, 5, 4, 31)) begin
      bad++; $display("FAIL tick_day_inc: got %s want %s", fmt(snap), fmt(mk(2024, 2, 2, 5, 4, 31)));
    end
  endtask

  task automatic test_set_errors();
    int lat; logic done, err;
    do_set(2100, 1, 29, lat, done, err);
    total++;
    if (lat !== 103 || err !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL err_2100_feb29: got lat=%0d err=%b done=%b want 103 1 0", lat, err, done);
    end
    total++;
    if (snap !== mk(2024, 2, 2, 5, 4, 31)) begin
      bad++; $display("FAIL err_keeps_date: got %s want %s", fmt(snap), fmt(mk(2024, 2, 2, 5, 4, 31)));
    end
    do_set(3000, 0, 1, lat, done, err);
    total++;
    if (lat !== 2 || err !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL err_year_range: got lat=%0d err=%b done=%b want 2 1 0", lat, err, done);
    end
    do_set(2005, 12, 1, lat, done, err);
    total++;
    if (lat !== 2 || err !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL err_month_range: got lat=%0d err=%b done=%b want 2 1 0", lat, err, done);
    end
    do_set(2001, 0, 0, lat, done, err);
    total++;
    if (lat !== 3 || err !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL err_day_zero: got lat=%0d err=%b done=%b want 3 1 0", lat, err, done);
    end
    do_set(2000, 1, 29, lat, done, err);
    total++;
    if (lat !== 3 || done !== 1'b1 || snap !== mk(2000, 1, 29, 1, 1, 29)) begin
      bad++; $display("FAIL set_2000_feb29: got lat=%0d done=%b %s want 3 1 %s",
                      lat, done, fmt(snap), fmt(mk(2000, 1, 29, 1, 1, 29)));
    end
  endtask

  task automatic test_year_roll();
    int lat; logic done, err;
    do_set(2023, 11, 31, lat, done, err);
    total++;
    if (lat !== 36 || done !== 1'b1 || snap !== mk(2023, 11, 31, 6, 4, 31)) begin
      bad++; $display("FAIL set_2023_dec31: got lat=%0d done=%b %s want 36 1 %s",
                      lat, done, fmt(snap), fmt(mk(2023, 11, 31, 6, 4, 31)));
    end
    tick();
    total++;
    if (snap !== mk(2024, 0, 1, 0, 0, 31)) begin
      bad++; $display("FAIL tick_new_year: got %s want %s", fmt(snap), fmt(mk(2024, 0, 1, 0, 0, 31)));
    end
  endtask

  // Tick held high for 60 consecutive cycles from 2024-01-01.
  task automatic test_back_to_back();
    logic [31:0] e;
    exp_at_q.push_back(31); exp_q.push_back(mk(2024, 1, 1, 3, 3, 29));
    exp_at_q.push_back(59); exp_q.push_back(mk(2024, 1, 29, 3, 3, 29));
    exp_at_q.push_back(60); exp_q.push_back(mk(2024, 2, 1, 4, 4, 31));
    @(negedge clk); day_tick = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 60) day_tick = 1'b0;
      if (exp_at_q.size() > 0 && exp_at_q[0] == i) begin
        void'(exp_at_q.pop_front());
        e = exp_q.pop_front();
        total++;
        if (snap !== e) begin
          bad++; $display("FAIL b2b_tick_%0d: got %s want %s", i, fmt(snap), fmt(e));
        end
      end
    end
  endtask

  task automatic test_max_wrap();
    int lat; logic done, err;
    do_set(2999, 11, 31, lat, done, err);
    total++;
    if (lat !== 1012 || done !== 1'b1 || snap !== mk(2999, 11, 31, 1, 6, 31)) begin
      bad++; $display("FAIL set_2999_dec31: got lat=%0d done=%b %s want 1012 1 %s",
                      lat, done, fmt(snap), fmt(mk(2999, 11, 31, 1, 6, 31)));
    end
    tick();
    total++;
    if (snap !== mk(2000, 0, 1, 5, 5, 31)) begin
      bad++; $display("FAIL wrap_to_2000: got %s want %s", fmt(snap), fmt(mk(2000, 0, 1, 5, 5, 31)));
    end
  endtask

  // Tick raised together with the set request and held into the walk.
  task automatic test_tick_during_walk();
    int lat; logic done;
    @(negedge clk);
    set_year = 12'd2010; set_month = 4'd0; set_day = 5'd5;
    set_valid = 1'b1; day_tick = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    lat = 1; done = set_done;
    while (!done && lat < 100) begin
      @(negedge clk);
      if (lat == 3) day_tick = 1'b0;
      lat++; done = set_done;
    end
    day_tick = 1'b0;
    total++;
    if (lat !== 12 || done !== 1'b1 || snap !== mk(2010, 0, 5, 1, 4, 31)) begin
      bad++; $display("FAIL tick_dropped_in_walk: got lat=%0d done=%b %s want 12 1 %s",
                      lat, done, fmt(snap), fmt(mk(2010, 0, 5, 1, 4, 31)));
    end
  endtask

  task automatic test_reset_mid_walk();
    logic seen;
    @(negedge clk);
    set_year = 12'd2500; set_month = 4'd0; set_day = 5'd1; set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (snap !== mk(2000, 0, 1, 5, 5, 31) || set_ready !== 1'b1 || fsm_state !== 2'd0) begin
      bad++; $display("FAIL async_reset_mid_walk: got %s ready=%b state=%0d want %s ready=1 state=0",
                      fmt(snap), set_ready, fsm_state, fmt(mk(2000, 0, 1, 5, 5, 31)));
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (set_done || set_err) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || set_ready !== 1'b1) begin
      bad++; $display("FAIL reset_discards_set: got pulse=%b ready=%b want 0 1", seen, set_ready);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; day_tick = 1'b0; set_valid = 1'b0;
    set_year = '0; set_month = '0; set_day = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_set_leap();
    test_tick_month_end();
    test_set_errors();
    test_year_roll();
    test_back_to_back();
    test_max_wrap();
    test_tick_during_walk();
    test_reset_mid_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
